// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } demux_state_t;

  function automatic logic route_valid(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_out_slice.sv
// One-entry output register with load and pass-through drain.
module demux_out_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              can_load
);

  assign can_load = !valid || ready;

  // load is only raised when can_load holds, so a stalled entry never changes
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with packet-locked routing and drop counting.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = $clog2(N_OUT),
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  input  logic [SEL_W-1:0]        s_sel,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic                    busy,
  output logic [CNT_W-1:0]        drop_count
);

  demux_state_t     state;
  demux_state_t     state_nxt;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] route;
  logic             route_ok;
  logic             accept;
  logic             drop;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] can_load;
  logic [N_OUT-1:0] load;

  assign route    = (state == LOCK) ? cur_sel : s_sel;
  assign route_ok = route_valid(32'(route), N_OUT);

  // s_ready depends on route and m_ready only, never on s_valid
  assign s_ready = route_ok ? |(hit & can_load) : 1'b1;
  assign accept  = s_valid && s_ready;
  assign load    = {N_OUT{accept}} & hit;
  assign drop    = accept && !route_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slice
    assign hit[k] = (route == SEL_W'(k));

    demux_out_slice #(
      .DATA_W(DATA_W)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(s_data),
      .load_last(s_last),
      .ready    (m_ready[k]),
      .valid    (m_valid[k]),
      .data     (m_data[k*DATA_W +: DATA_W]),
      .last     (m_last[k]),
      .can_load (can_load[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !s_last) state_nxt = LOCK;
      LOCK:    if (accept && s_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel <= '0;
    end else if (state == IDLE && accept && !s_last) begin
      cur_sel <= s_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: directed packets, backpressure, drops, saturation, reset.
module tb_stream_demux;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_data;
  logic                    s_last;
  logic [SEL_W-1:0]        s_sel;
  logic [N_OUT-1:0]        m_valid;
  logic [N_OUT-1:0]        m_ready;
  logic [N_OUT*DATA_W-1:0] m_data;
  logic [N_OUT-1:0]        m_last;
  logic                    busy;
  logic [CNT_W-1:0]        drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected {last, data} per channel
  logic [8:0] exp_q [N_OUT][$];

  stream_demux #(
    .DATA_W(DATA_W),
    .N_OUT (N_OUT),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_sel     (s_sel),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (m_valid[k] && m_ready[k]) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL ch%0d_unexpected: got %h, expected nothing", k, {m_last[k], m_data[k*DATA_W +: DATA_W]});
          end else begin
            logic [8:0] e;
            e = exp_q[k].pop_front();
            if ({m_last[k], m_data[k*DATA_W +: DATA_W]} !== e) begin
              n_fail++;
              $display("FAIL ch%0d_beat: got %h, expected %h", k, {m_last[k], m_data[k*DATA_W +: DATA_W]}, e);
            end
          end
        end
      end
    end
  end

  // exp_ch >= N_OUT marks a beat that must be dropped
  task automatic send_beat(input logic [SEL_W-1:0] sel, input logic [7:0] data, input logic last,
                           input int exp_ch, input logic exp_busy);
    int waited = 0;
    bit acc = 0;
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    s_last  = last;
    while (!acc && waited < 20) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1;
        check("busy_at_accept", 32'(busy), 32'(exp_busy));
        if (exp_ch < N_OUT) exp_q[exp_ch].push_back({last, data});
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'(acc), 32'(1));
    end else if (exp_ch < N_OUT) begin
      check("latency_valid", 32'(m_valid[exp_ch]), 32'(1));
      check("latency_data", 32'(m_data[exp_ch*DATA_W +: DATA_W]), 32'(data));
      check("latency_last", 32'(m_last[exp_ch]), 32'(last));
    end else begin
      check("drop_ready_first", 32'(waited), 32'(0));
      check("drop_no_valid", 32'(m_valid), 32'(0));
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_sel   = '0;
    m_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_data", 32'(m_data), 32'(0));
    check("rst_m_last", 32'(m_last), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_drop", 32'(drop_count), 32'(0));
    rst = 1'b0;

    send_beat(3'd2, 8'h11, 1'b0, 2, 1'b0);
    send_beat(3'd2, 8'h22, 1'b0, 2, 1'b1);
    send_beat(3'd2, 8'h33, 1'b1, 2, 1'b1);
    check("busy_after_pkt", 32'(busy), 32'(0));

    send_beat(3'd1, 8'hA1, 1'b0, 1, 1'b0);
    send_beat(3'd3, 8'hA2, 1'b0, 1, 1'b1);
    send_beat(3'd3, 8'hA3, 1'b1, 1, 1'b1);

    m_ready = 4'b1110;
    send_beat(3'd0, 8'hB0, 1'b1, 0, 1'b0);
    s_valid = 1'b1;
    s_sel   = 3'd0;
    s_data  = 8'hB1;
    s_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", 32'(s_ready), 32'(0));
      check("stall_hold_data", 32'(m_data[7:0]), 32'h0B0);
      check("stall_hold_valid", 32'(m_valid[0]), 32'(1));
      @(posedge clk);
      #1;
    end
    m_ready = 4'hF;
    send_beat(3'd0, 8'hB1, 1'b1, 0, 1'b0);
    send_beat(3'd3, 8'hC3, 1'b1, 3, 1'b0);

    send_beat(3'd5, 8'hD0, 1'b0, N_OUT, 1'b0);
    send_beat(3'd1, 8'hD1, 1'b0, N_OUT, 1'b1);
    send_beat(3'd5, 8'hD2, 1'b0, N_OUT, 1'b1);
    send_beat(3'd5, 8'hD3, 1'b1, N_OUT, 1'b1);
    check("drop_count_4", 32'(drop_count), 32'(4));
    check("busy_after_drop", 32'(busy), 32'(0));

    for (int i = 0; i < 3; i++) send_beat(3'd6, 8'hE0, 1'b1, N_OUT, 1'b0);
    check("drop_count_sat", 32'(drop_count), 32'(7));
    for (int i = 0; i < 2; i++) send_beat(3'd7, 8'hE1, 1'b1, N_OUT, 1'b0);
    check("drop_count_hold", 32'(drop_count), 32'(7));

    m_ready = 4'b1110;
    send_beat(3'd0, 8'hF0, 1'b0, 0, 1'b0);
    s_valid = 1'b1;
    s_sel   = 3'd0;
    s_data  = 8'hF1;
    s_last  = 1'b1;
    check("lock_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q[0].delete();
    check("mid_rst_m_valid", 32'(m_valid), 32'(0));
    check("mid_rst_m_data", 32'(m_data), 32'(0));
    check("mid_rst_m_last", 32'(m_last), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_drop", 32'(drop_count), 32'(0));
    rst     = 1'b0;
    s_valid = 1'b0;
    m_ready = 4'hF;
    send_beat(3'd3, 8'h5A, 1'b1, 3, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < N_OUT; k++) check("queue_empty", 32'(exp_q[k].size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake and packet-locked routing. Each input beat is steered to one of `N_OUT` outputs by `s_sel`, which is sampled on the first beat of a packet and held until the `s_last` beat. Beats addressed to a non-existent output are consumed and counted. This block is the successor to the combinational 1x2/1x4 demux trees; it is used wherever a stream fans out to several consumers that can stall independently.

## Interface
Parameters:
- `DATA_W`, 8, payload width in bits.
- `N_OUT`, 4, number of output channels; must be at least 2.
- `SEL_W`, `$clog2(N_OUT)`, select width; may be set wider to allow out-of-range codes.
- `CNT_W`, 16, width of the drop counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  DATA_W  input payload.
- `s_last`  in  1  final beat of the packet.
- `s_sel`  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- `m_valid`  out  N_OUT  per-channel output valid.
- `m_ready`  in  N_OUT  per-channel output ready.
- `m_data`  out  N_OUT*DATA_W  per-channel payload; channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `m_last`  out  N_OUT  per-channel last flag.
- `busy`  out  1  high while a packet is locked (state LOCK).
- `drop_count`  out  CNT_W  number of dropped beats; saturates.

## Operation
- FSM states:
  - IDLE: the route is taken from `s_sel` on each accepted beat.
  - LOCK: the route is taken from the internal `cur_sel`.
- State transitions:
  - IDLE→LOCK on an accepted beat with `s_last=0`; `cur_sel` latches `s_sel` on that beat.
  - LOCK→IDLE on an accepted beat with `s_last=1`.
  - A single-beat packet (`s_last=1` in IDLE) leaves the FSM in IDLE.
  - `s_sel` is ignored while in LOCK.
- Route validity:
  - A route r is valid when r < N_OUT.
  - An invalid route is a drop route. The whole packet is dropped, including its locked remainder.
- Per-channel output slice: one entry (`valid`, `data`, `last`).
  - The slice can load when it is empty, or when `m_ready[k]` is high in the same cycle (pass-through drain).
- `s_ready` for a valid route equals the load condition of the routed slice. For a drop route `s_ready=1`.
- `s_ready` depends combinationally on `m_ready` and on the route. There is no combinational path from `s_valid` to `s_ready`.
- On an accepted valid-route beat, the routed slice loads `s_data`/`s_last` and sets its valid at the next edge.
- On an accepted drop-route beat:
  - No slice changes.
  - `drop_count` increments by 1 and saturates at 2^CNT_W−1.
- Non-routed slices continue to drain independently; one stalled channel never blocks an accepted beat bound for another channel.
- A slice clears its valid when `m_ready[k]` is high and no new load occurs in that cycle.

## Timing
- Latency: 1 cycle from acceptance to `m_valid`. Throughput: one beat per cycle per channel while `m_ready` is held high.
- Reset values:
  - All `m_valid`, `m_last` and `m_data` = 0.
  - `drop_count` = 0, `busy` = 0.
  - State = IDLE, `cur_sel` = 0.
- Reset mid-packet:
  - Buffered beats are discarded and the lock is released.
  - The first beat after reset is treated as a packet start.
- Simultaneous drain and load on the same slice: the new beat is written and `m_valid` stays high, with no bubble.
- Output stability: once `m_valid[k]` is high, `m_data` and `m_last` of that channel hold until the handshake completes.
- Counter: at saturation it holds its value. A drop beat and reset in the same cycle gives 0.

## Structure
- Package `stream_demux_pkg` holds:
  - the FSM state enum `demux_state_t` with values IDLE and LOCK;
  - the helper function `route_valid(sel, n)`.
- Sub-module `demux_out_slice` (parameter `DATA_W`) implements the one-entry register with load/drain logic. It is instantiated N_OUT times in a generate loop.
- The top level holds the FSM, route mux, `s_ready` mux and drop counter.

## Test plan
- Reset release with N_OUT=4 and all `m_ready=1`: drive 3 beats with `s_sel=2`, data 0x11/0x22/0x33, last on the third. Expect channel 2 to output 0x11/0x22/0x33 on consecutive cycles, each one cycle after acceptance, with `m_last` set on 0x33 and `busy` high for the second and third beats only.
- Packet lock: start a packet with `s_sel=1`, then change `s_sel` to 3 mid-packet. Expect all beats on channel 1 and none on channel 3.
- Backpressure isolation:
  - Hold `m_ready[0]=0` with its slice full; `s_ready` must be 0 for a channel-0 packet.
  - A subsequent single-beat packet to channel 3 is accepted only after channel 0 drains. This is in-order blocking at the input, and is the required behaviour.
- Drop: with SEL_W=3, send a 4-beat packet with `s_sel=5`. Expect `s_ready=1` throughout, no `m_valid`, and `drop_count` going 0→4.
- Saturation and reset: with CNT_W=2, drop 5 beats and expect `drop_count=3`. Then assert `rst` mid-packet on channel 0 with the slice full. Expect all outputs to return to their reset values and the next beat's `s_sel` to be honoured.
